// File: rtl/vfpu_result_buffer.sv
// -----------------------------------------------------------------------------
// vfpu_result_buffer
//
// Captures every result the VFPU datapath emits (result word, IEEE exception
// flags, issue tag). The results are held in a first-word-fall-through FIFO
// and drained to the platform monitor/scoreboard over a valid/ready handshake.
// The VFPU has no backpressure, so a result that arrives while the FIFO is full
// and not being popped is dropped, and the sticky overflow bit is set. A
// saturating result counter and a sticky OR of the exception flags support
// end-of-test checks.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   clr             synchronous clear of overflow, flag_acc, result_cnt
//   in_valid        result valid from the VFPU (no ready is returned)
//   in_data/flags/tag  result word, {NV,DZ,OF,UF,NX}, issue tag
//   out_valid/ready handshake toward the consumer
//   out_data/flags/tag head entry, forced to zero while empty
//   level           occupancy 0..DEPTH
//   full, empty     derived from level
//   overflow        sticky: at least one result was dropped
//   flag_acc        sticky OR of the flags of all accepted results
//   result_cnt      saturating count of accepted results
//
// DEPTH must be a power of two and at least 2, because the pointers wrap by
// natural binary overflow.
// -----------------------------------------------------------------------------
module vfpu_result_buffer #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 5,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [FLAG_W-1:0]          in_flags,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [FLAG_W-1:0]          out_flags,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [FLAG_W-1:0]          flag_acc,
    output logic [CNT_W-1:0]           result_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + FLAG_W + TAG_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] head;

    logic push;
    logic pop;
    logic drop;

    // full/empty decode only the level register, so they change only at a
    // clock edge.
    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign out_valid = !empty;

    assign pop  = out_valid && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    // Pointers, level
    // NOTE: sequential state uses non-blocking assignments only. The other
    // always_ff blocks then all see the pre-edge values of push, pop and level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage
    // NOTE: the storage array has no reset. Only the pointers and the level
    // define which entries are valid, and leaving the array unreset lets it map
    // onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= {in_data, in_flags, in_tag};
        end
    end

    // First-word-fall-through head. The outputs are masked to zero while the
    // FIFO is empty, so stale entries are never visible.
    assign head      = mem[rd_ptr];
    assign out_data  = empty ? '0 : head[ENTRY_W-1 -: DATA_W];
    assign out_flags = empty ? '0 : head[TAG_W +: FLAG_W];
    assign out_tag   = empty ? '0 : head[TAG_W-1:0];

    // Statistics. With clr, this cycle's push or drop is folded into the
    // cleared values, so nothing that happens in the clr cycle is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            flag_acc   <= '0;
            result_cnt <= '0;
        end else if (clr) begin
            overflow   <= drop;
            flag_acc   <= push ? in_flags : '0;
            result_cnt <= push ? CNT_W'(1) : '0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (push) begin
                flag_acc <= flag_acc | in_flags;
                if (result_cnt != '1) result_cnt <= result_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vfpu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_vfpu_result_buffer
//
// Directed bench for vfpu_result_buffer. Instance dut uses the default
// parameters. Instance dut_c4 uses CNT_W=4 to reach counter saturation
// quickly. Inputs change 1 time unit after each rising edge. Outputs are
// sampled at that same point, after the state has settled.
// -----------------------------------------------------------------------------
module tb_vfpu_result_buffer;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, out_ready;
    logic [31:0] in_data;
    logic [4:0]  in_flags;
    logic [3:0]  in_tag;
    logic        out_valid, full, empty, overflow;
    logic [31:0] out_data;
    logic [4:0]  out_flags, flag_acc;
    logic [3:0]  out_tag;
    logic [3:0]  level;
    logic [15:0] result_cnt;

    logic        c_rst, c_clr, c_in_valid, c_out_ready;
    logic [31:0] c_in_data;
    logic [4:0]  c_in_flags;
    logic [3:0]  c_in_tag;
    logic        c_out_valid, c_full, c_empty, c_overflow;
    logic [31:0] c_out_data;
    logic [4:0]  c_out_flags, c_flag_acc;
    logic [3:0]  c_out_tag;
    logic [3:0]  c_level;
    logic [3:0]  c_result_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vfpu_result_buffer dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_flags(in_flags), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags), .out_tag(out_tag),
        .level(level), .full(full), .empty(empty),
        .overflow(overflow), .flag_acc(flag_acc), .result_cnt(result_cnt)
    );

    vfpu_result_buffer #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(c_rst), .clr(c_clr),
        .in_valid(c_in_valid), .in_data(c_in_data), .in_flags(c_in_flags), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_flags(c_out_flags), .out_tag(c_out_tag),
        .level(c_level), .full(c_full), .empty(c_empty),
        .overflow(c_overflow), .flag_acc(c_flag_acc), .result_cnt(c_result_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Drive every other input active: rst must still win.
        rst = 1'b1; clr = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_data = 32'h1234_5678; in_flags = 5'b11111; in_tag = 4'hF;
        tick();
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        total++; if ({empty, full, out_valid} !== 3'b100) begin bad++; $display("FAIL reset_flags: got e/f/v=%b want 100", {empty, full, out_valid}); end
        total++; if ({overflow, flag_acc, result_cnt} !== 22'd0) begin bad++; $display("FAIL reset_stats: got ovf=%b acc=%b cnt=%0d want 0/0/0", overflow, flag_acc, result_cnt); end
        total++; if ({out_data, out_flags, out_tag} !== 41'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", {out_data, out_flags, out_tag}); end
    endtask

    task automatic test_push_pop();
        logic [31:0] words [3];
        words[0] = 32'h3F80_0000; words[1] = 32'h4000_0000; words[2] = 32'h4040_0000;
        do_reset();
        in_flags = 5'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i]; in_tag = 4'(i + 1);
            tick();
            // The first word is visible the cycle after its in_valid, with no bypass.
            if (i == 0) begin
                total++; if (out_valid !== 1'b1 || out_data !== words[0] || out_tag !== 4'd1) begin bad++; $display("FAIL pp_first_latency: got v=%b d=%h t=%0d want 1/%h/1", out_valid, out_data, out_tag, words[0]); end
            end
        end
        in_valid = 1'b0;
        total++; if (level !== 4'd3) begin bad++; $display("FAIL pp_level3: got %0d want 3", level); end
        tick();
        total++; if (out_data !== words[0] || out_tag !== 4'd1) begin bad++; $display("FAIL pp_head_hold: got %h/%0d want %h/1", out_data, out_tag, words[0]); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== words[i] || out_tag !== 4'(i + 1)) begin bad++; $display("FAIL pp_pop_order[%0d]: got v=%b d=%h t=%0d want 1/%h/%0d", i, out_valid, out_data, out_tag, words[i], i + 1); end
            tick();
        end
        total++; if (level !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL pp_drained: got lvl=%0d e=%b v=%b want 0/1/0", level, empty, out_valid); end
        total++; if ({out_data, out_flags, out_tag} !== 41'd0) begin bad++; $display("FAIL pp_empty_mask: got %h want 0", {out_data, out_flags, out_tag}); end
        // out_ready while empty must not move anything.
        tick();
        total++; if (level !== 4'd0 || result_cnt !== 16'd3) begin bad++; $display("FAIL pp_ready_empty: got lvl=%0d cnt=%0d want 0/3", level, result_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        in_flags = 5'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 32'h100 + 32'(i); in_tag = 4'(i);
            tick();
        end
        total++; if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin bad++; $display("FAIL ov_full: got f=%b lvl=%0d ovf=%b want 1/8/0", full, level, overflow); end
        in_data = 32'hDEAD_BEEF; in_flags = 5'b00001; in_tag = 4'hF;
        tick();
        in_valid = 1'b0; in_flags = 5'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ov_sticky_set: got %b want 1", overflow); end
        total++; if (result_cnt !== 16'd8 || flag_acc !== 5'b0 || level !== 4'd8) begin bad++; $display("FAIL ov_drop_stats: got cnt=%0d acc=%b lvl=%0d want 8/00000/8", result_cnt, flag_acc, level); end
        tick();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ov_sticky_hold: got %b want 1", overflow); end
    endtask

    // Runs from the full FIFO left by test_overflow.
    task automatic test_back_to_back();
        logic [31:0] expect_q [$];
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (overflow !== 1'b0 || result_cnt !== 16'd0 || level !== 4'd8) begin bad++; $display("FAIL b2b_clr: got ovf=%b cnt=%0d lvl=%0d want 0/0/8", overflow, result_cnt, level); end
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h200 + 32'(i); in_tag = 4'(i);
            total++; if (out_data !== 32'h100 + 32'(i)) begin bad++; $display("FAIL b2b_head[%0d]: got %h want %h", i, out_data, 32'h100 + 32'(i)); end
            tick();
            total++; if (level !== 4'd8 || overflow !== 1'b0) begin bad++; $display("FAIL b2b_level[%0d]: got lvl=%0d ovf=%b want 8/0", i, level, overflow); end
        end
        in_valid = 1'b0;
        total++; if (result_cnt !== 16'd4) begin bad++; $display("FAIL b2b_cnt: got %0d want 4", result_cnt); end
        for (int i = 4; i < 8; i++) expect_q.push_back(32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) expect_q.push_back(32'h200 + 32'(i));
        // The dropped 0xDEADBEEF word must never appear in this drain order.
        for (int i = 0; i < 8; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== expect_q[i]) begin bad++; $display("FAIL b2b_drain[%0d]: got v=%b d=%h want 1/%h", i, out_valid, out_data, expect_q[i]); end
            tick();
        end
        out_ready = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %b want 1", empty); end
    endtask

    task automatic test_flags_clr();
        logic [4:0] fl [3];
        fl[0] = 5'b10000; fl[1] = 5'b00100; fl[2] = 5'b00001;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'(i); in_tag = 4'(i); in_flags = fl[i];
            tick();
        end
        in_valid = 1'b0;
        total++; if (flag_acc !== 5'b10101 || result_cnt !== 16'd3) begin bad++; $display("FAIL fl_accum: got acc=%b cnt=%0d want 10101/3", flag_acc, result_cnt); end
        clr = 1'b1; in_valid = 1'b1; in_flags = 5'b01000;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        total++; if (flag_acc !== 5'b01000 || result_cnt !== 16'd1 || overflow !== 1'b0) begin bad++; $display("FAIL fl_clr_push: got acc=%b cnt=%0d ovf=%b want 01000/1/0", flag_acc, result_cnt, overflow); end
        total++; if (level !== 4'd4) begin bad++; $display("FAIL fl_clr_keeps_fifo: got %0d want 4", level); end
        // Fill to full. A clr in the same cycle as a drop leaves overflow set.
        in_flags = 5'b00010;
        for (int i = 0; i < 4; i++) begin in_valid = 1'b1; tick(); end
        clr = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        total++; if (overflow !== 1'b1 || result_cnt !== 16'd0 || flag_acc !== 5'b0) begin bad++; $display("FAIL fl_clr_drop: got ovf=%b cnt=%0d acc=%b want 1/0/00000", overflow, result_cnt, flag_acc); end
        // clr with no push or drop zeroes all three.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (overflow !== 1'b0 || result_cnt !== 16'd0 || flag_acc !== 5'b0) begin bad++; $display("FAIL fl_clr_idle: got ovf=%b cnt=%0d acc=%b want 0/0/00000", overflow, result_cnt, flag_acc); end
    endtask

    task automatic test_saturation();
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0;
        c_in_valid = 1'b1; c_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            c_in_data = 32'(i); c_in_tag = 4'(i);
            tick();
            if (i == 14) begin
                total++; if (c_result_cnt !== 4'd15) begin bad++; $display("FAIL sat_reach: got %0d want 15", c_result_cnt); end
            end
        end
        c_in_valid = 1'b0; c_out_ready = 1'b0;
        total++; if (c_result_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d want 15", c_result_cnt); end
        total++; if (c_level !== 4'd1 || c_out_data !== 32'd19) begin bad++; $display("FAIL sat_level: got lvl=%0d d=%0d want 1/19", c_level, c_out_data); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        in_flags = 5'b00100;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = 32'h300 + 32'(i); in_tag = 4'(i);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        total++; if (level !== 4'd5 || overflow !== 1'b1) begin bad++; $display("FAIL rm_setup: got lvl=%0d ovf=%b want 5/1", level, overflow); end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'hBAD0_0000;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (level !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rm_fifo: got lvl=%0d e=%b v=%b want 0/1/0", level, empty, out_valid); end
        total++; if (overflow !== 1'b0 || result_cnt !== 16'd0 || flag_acc !== 5'b0) begin bad++; $display("FAIL rm_stats: got ovf=%b cnt=%0d acc=%b want 0/0/00000", overflow, result_cnt, flag_acc); end
        in_valid = 1'b1; in_data = 32'hCAFE_F00D; in_tag = 4'd7; in_flags = 5'b00010;
        tick();
        in_valid = 1'b0;
        total++; if (level !== 4'd1 || out_data !== 32'hCAFE_F00D || out_tag !== 4'd7 || out_flags !== 5'b00010) begin bad++; $display("FAIL rm_push_after: got lvl=%0d d=%h t=%0d f=%b want 1/cafef00d/7/00010", level, out_data, out_tag, out_flags); end
        total++; if (result_cnt !== 16'd1 || flag_acc !== 5'b00010) begin bad++; $display("FAIL rm_stats_after: got cnt=%0d acc=%b want 1/00010", result_cnt, flag_acc); end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_flags = '0; in_tag = '0;
        c_rst = 1'b1; c_clr = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0;
        c_in_data = '0; c_in_flags = '0; c_in_tag = '0;
        tick();
        test_reset();
        test_push_pop();
        test_overflow();
        test_back_to_back();
        test_flags_clr();
        test_saturation();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
